cordic_iter_ctrl: RTL and testbench

Iteration sequencer for the natural-logarithm datapath's hyperbolic CORDIC. It sits at the control end of the 5-bit iteration counter interface. It accepts a start request, pulses an operand-load strobe, then enables the datapath once per iteration while presenting the current shift index. It finishes with a held completion flag that the consumer must acknowledge.

---
 rtl/cordic_ctrl_pkg.sv | 18 +
 rtl/iter_idx_counter.sv | 28 ++
 rtl/cordic_iter_ctrl.sv | 130 +++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_ctrl_pkg.sv
// Shared types and constants for the hyperbolic CORDIC iteration sequencer.
package cordic_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StIter   = 2'd2,
    StFinish = 2'd3
  } state_e;

  // Hyperbolic CORDIC needs these shift indices repeated for convergence.
  localparam int unsigned REPEAT_IDX_A = 4;
  localparam int unsigned REPEAT_IDX_B = 13;

  // Hyperbolic index 0 is undefined (atanh(1)), so iteration starts at 1.
  localparam int unsigned FIRST_IDX = 1;

endpackage

// File: rtl/iter_idx_counter.sv
// Shift-index up counter: synchronous clear, load-to-first-index and hold.
module iter_idx_counter #(
  parameter int unsigned IW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic          hold,
  output logic [IW-1:0] idx
);
  import cordic_ctrl_pkg::*;

  logic [IW-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx_q <= '0;
    end else if (load) begin
      idx_q <= IW'(FIRST_IDX);
    end else if (!hold) begin
      idx_q <= idx_q + IW'(1);
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iteration sequencer for the hyperbolic CORDIC in the ln datapath.
// Define HYP_REPEAT_EN to repeat shift indices 4 and 13.
module cordic_iter_ctrl #(
  parameter int unsigned ITERS = 25,
  parameter int unsigned IW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ack,
  output logic          busy,
  output logic          load_reg,
  output logic          en_iter,
  output logic [IW-1:0] iter_idx,
  output logic          done
);
  import cordic_ctrl_pkg::*;

  localparam logic [IW-1:0] LastIdx = IW'(ITERS);

  state_e state_q;
  logic   cnt_clr, cnt_load, cnt_hold;
  logic   rep_pending;
  logic   last;

`ifdef HYP_REPEAT_EN
  localparam logic [IW-1:0] RepIdxA = IW'(REPEAT_IDX_A);
  localparam logic [IW-1:0] RepIdxB = IW'(REPEAT_IDX_B);

  logic repeat_done_q;
  logic is_rep_idx;

  // Index B only exists when the run is long enough to reach it.
  assign is_rep_idx = ((ITERS >= REPEAT_IDX_A) && (iter_idx == RepIdxA)) ||
                      ((ITERS >= REPEAT_IDX_B) && (iter_idx == RepIdxB));
  assign rep_pending = (state_q == StIter) && is_rep_idx && !repeat_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      repeat_done_q <= 1'b0;
    end else if (state_q == StIter) begin
      repeat_done_q <= rep_pending;
    end else begin
      repeat_done_q <= 1'b0;
    end
  end
`else
  assign rep_pending = 1'b0;
`endif

  assign last = (state_q == StIter) && (iter_idx == LastIdx) && !rep_pending;

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_hold = 1'b1;
    unique case (state_q)
      StIdle:   cnt_clr = 1'b1;
      StLoad:   cnt_load = 1'b1;
      StIter: begin
        if (last) begin
          cnt_clr = 1'b1;
        end else begin
          cnt_hold = rep_pending;
        end
      end
      StFinish: cnt_clr = 1'b1;
      default:  cnt_clr = 1'b1;
    endcase
  end

  iter_idx_counter #(
    .IW(IW)
  ) u_idx_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .load (cnt_load),
    .hold (cnt_hold),
    .idx  (iter_idx)
  );

  // Outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      busy     <= 1'b0;
      load_reg <= 1'b0;
      en_iter  <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StLoad;
            busy     <= 1'b1;
            load_reg <= 1'b1;
          end
        end
        StLoad: begin
          state_q  <= StIter;
          load_reg <= 1'b0;
          en_iter  <= 1'b1;
        end
        StIter: begin
          if (last) begin
            state_q <= StFinish;
            busy    <= 1'b0;
            en_iter <= 1'b0;
            done    <= 1'b1;
          end
        end
        StFinish: begin
          if (ack) begin
            state_q <= StIdle;
            done    <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          busy     <= 1'b0;
          load_reg <= 1'b0;
          en_iter  <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench for cordic_iter_ctrl (default ITERS=25 and ITERS=4 instances).
module tb_cordic_iter_ctrl;

  localparam int unsigned ITERS_A = 25;
  localparam int unsigned IW_A    = 5;
  localparam int unsigned ITERS_B = 4;
  localparam int unsigned IW_B    = 3;
`ifdef HYP_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, ack_a = 1'b0;
  logic start_b = 1'b0, ack_b = 1'b0;
  logic busy_a, load_a, en_a, done_a;
  logic busy_b, load_b, en_b, done_b;
  logic [IW_A-1:0] idx_a;
  logic [IW_B-1:0] idx_b;

  int n_cmp = 0;
  int n_err = 0;
  int exp_a[$];
  int exp_b[$];

  always #5 clk = ~clk;

  cordic_iter_ctrl #(.ITERS(ITERS_A), .IW(IW_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ack(ack_a), .busy(busy_a),
    .load_reg(load_a), .en_iter(en_a), .iter_idx(idx_a), .done(done_a)
  );

  cordic_iter_ctrl #(.ITERS(ITERS_B), .IW(IW_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ack(ack_b), .busy(busy_b),
    .load_reg(load_b), .en_iter(en_b), .iter_idx(idx_b), .done(done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vectors below are {busy, load_reg, en_iter, done, iter_idx}.
  task automatic test_reset();
    logic [8:0] got_a;
    logic [6:0] got_b;
    rst = 1'b1; start_a = 1'b1; ack_a = 1'b1; start_b = 1'b1; ack_b = 1'b1;
    tick(); tick();
    got_a = {busy_a, load_a, en_a, done_a, idx_a};
    got_b = {busy_b, load_b, en_b, done_b, idx_b};
    n_cmp++;
    if (got_a !== 9'd0) begin
      n_err++; $display("FAIL reset_a got=%h exp=%h", got_a, 9'd0);
    end
    n_cmp++;
    if (got_b !== 7'd0) begin
      n_err++; $display("FAIL reset_b got=%h exp=%h", got_b, 7'd0);
    end
    rst = 1'b0; start_a = 1'b0; ack_a = 1'b0; start_b = 1'b0; ack_b = 1'b0;
    tick();
    got_a = {busy_a, load_a, en_a, done_a, idx_a};
    n_cmp++;
    if (got_a !== 9'd0) begin
      n_err++; $display("FAIL idle_after_reset got=%h exp=%h", got_a, 9'd0);
    end
  endtask

  task automatic test_full_sequence(input int ack_delay, input bit noise, input string tag);
    logic [8:0] got, exp;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    got = {busy_a, load_a, en_a, done_a, idx_a};
    exp = {4'b1100, 5'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL %s_load got=%h exp=%h", tag, got, exp);
    end
    foreach (exp_a[k]) begin
      ack_a   = noise ? 1'($urandom) : 1'b0;
      start_a = noise ? 1'($urandom) : 1'b0;
      tick();
      got = {busy_a, load_a, en_a, done_a, idx_a};
      exp = {4'b1010, 5'(exp_a[k])};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL %s_iter%0d got=%h exp=%h", tag, k, got, exp);
      end
    end
    ack_a = 1'b0; start_a = 1'b0;
    tick();
    got = {busy_a, load_a, en_a, done_a, idx_a};
    exp = {4'b0001, 5'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL %s_done got=%h exp=%h", tag, got, exp);
    end
    for (int d = 0; d < ack_delay; d++) begin
      start_a = noise ? 1'($urandom) : 1'b0;
      tick();
      got = {busy_a, load_a, en_a, done_a, idx_a};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL %s_hold%0d got=%h exp=%h", tag, d, got, exp);
      end
    end
    start_a = 1'b0; ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    got = {busy_a, load_a, en_a, done_a, idx_a};
    n_cmp++;
    if (got !== 9'd0) begin
      n_err++; $display("FAIL %s_ack got=%h exp=%h", tag, got, 9'd0);
    end
  endtask

  task automatic test_small_iters();
    logic [6:0] got, exp;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    got = {busy_b, load_b, en_b, done_b, idx_b};
    exp = {4'b1100, 3'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL small_load got=%h exp=%h", got, exp);
    end
    foreach (exp_b[k]) begin
      tick();
      got = {busy_b, load_b, en_b, done_b, idx_b};
      exp = {4'b1010, 3'(exp_b[k])};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL small_iter%0d got=%h exp=%h", k, got, exp);
      end
    end
    tick();
    got = {busy_b, load_b, en_b, done_b, idx_b};
    exp = {4'b0001, 3'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL small_done got=%h exp=%h", got, exp);
    end
    ack_b = 1'b1;
    tick();
    ack_b = 1'b0;
    got = {busy_b, load_b, en_b, done_b, idx_b};
    n_cmp++;
    if (got !== 7'd0) begin
      n_err++; $display("FAIL small_ack got=%h exp=%h", got, 7'd0);
    end
  endtask

  task automatic test_start_spam();
    logic [8:0] got, exp;
    start_a = 1'b1;
    tick();
    got = {busy_a, load_a, en_a, done_a, idx_a};
    exp = {4'b1100, 5'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL spam_load got=%h exp=%h", got, exp);
    end
    foreach (exp_a[k]) begin
      tick();
      got = {busy_a, load_a, en_a, done_a, idx_a};
      exp = {4'b1010, 5'(exp_a[k])};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL spam_iter%0d got=%h exp=%h", k, got, exp);
      end
    end
    exp = {4'b0001, 5'd0};
    for (int d = 0; d < 4; d++) begin
      tick();
      got = {busy_a, load_a, en_a, done_a, idx_a};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL spam_done%0d got=%h exp=%h", d, got, exp);
      end
    end
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    got = {busy_a, load_a, en_a, done_a, idx_a};
    n_cmp++;
    if (got !== 9'd0) begin
      n_err++; $display("FAIL spam_ack_with_start got=%h exp=%h", got, 9'd0);
    end
    tick();
    start_a = 1'b0;
    got = {busy_a, load_a, en_a, done_a, idx_a};
    exp = {4'b1100, 5'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL spam_restart got=%h exp=%h", got, exp);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {busy_a, load_a, en_a, done_a, idx_a};
    n_cmp++;
    if (got !== 9'd0) begin
      n_err++; $display("FAIL spam_rst got=%h exp=%h", got, 9'd0);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] got;
    int cyc = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    while (idx_a !== 5'd13 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (idx_a !== 5'd13 || en_a !== 1'b1) begin
      n_err++; $display("FAIL mid_reach13 idx=%0d en=%b exp idx=13 en=1", idx_a, en_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {busy_a, load_a, en_a, done_a, idx_a};
    n_cmp++;
    if (got !== 9'd0) begin
      n_err++; $display("FAIL mid_rst got=%h exp=%h", got, 9'd0);
    end
    for (int d = 0; d < 3; d++) begin
      tick();
      got = {busy_a, load_a, en_a, done_a, idx_a};
      n_cmp++;
      if (got !== 9'd0) begin
        n_err++; $display("FAIL mid_quiet%0d got=%h exp=%h", d, got, 9'd0);
      end
    end
  endtask

  task automatic test_done_hold();
    test_full_sequence(10, 1'b0, "hold10");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      test_full_sequence(int'($urandom_range(0, 4)), 1'b1, "b2b");
    end
  endtask

  initial begin
    for (int i = 1; i <= int'(ITERS_A); i++) begin
      exp_a.push_back(i);
      if (REP && (i == 4 || i == 13)) exp_a.push_back(i);
    end
    for (int i = 1; i <= int'(ITERS_B); i++) begin
      exp_b.push_back(i);
      if (REP && (i == 4 || i == 13)) exp_b.push_back(i);
    end
    test_reset();
    test_full_sequence(0, 1'b0, "basic");
    test_small_iters();
    test_start_spam();
    test_reset_mid();
    test_full_sequence(1, 1'b0, "after_rst");
    test_done_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
